alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 32-bit ALU, whose output mux selects one of 16 function results by a 4-bit select. It accepts operation requests over valid/ready channels and grants one requester at a time. It drives the ALU select and operands, waits the op's latency, and returns the captured result on a single tagged response channel. It sits between the two issue ports of the core and the ALU datapath.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_rr_arb2.sv | 31 +++
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: select codes, multi-cycle threshold, sequencer states.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'h0;
  localparam logic [3:0] ALU_OP_SUB  = 4'h1;
  localparam logic [3:0] ALU_OP_AND  = 4'h2;
  localparam logic [3:0] ALU_OP_OR   = 4'h3;
  localparam logic [3:0] ALU_OP_XOR  = 4'h4;
  localparam logic [3:0] ALU_OP_NOR  = 4'h5;
  localparam logic [3:0] ALU_OP_SLL  = 4'h6;
  localparam logic [3:0] ALU_OP_SRL  = 4'h7;
  localparam logic [3:0] ALU_OP_SRA  = 4'h8;
  localparam logic [3:0] ALU_OP_SLT  = 4'h9;
  localparam logic [3:0] ALU_OP_SLTU = 4'hA;
  localparam logic [3:0] ALU_OP_PASS = 4'hB;
  localparam logic [3:0] ALU_OP_MUL  = 4'hC;
  localparam logic [3:0] ALU_OP_MULH = 4'hD;
  localparam logic [3:0] ALU_OP_DIV  = 4'hE;
  localparam logic [3:0] ALU_OP_REM  = 4'hF;

  localparam logic [3:0] MULTI_OP_BASE = 4'b1100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic logic is_multi(input logic [3:0] op);
    return op >= MULTI_OP_BASE;
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-port round-robin grant: combinational grant when enabled, pointer moves past the winner.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) grant_o[ptr_q] = 1'b1;
      else                  grant_o = valid_i;
    end
  end

  // After any grant the pointer favours the port that did not win.
  always_comb begin
    ptr_d = ptr_q;
    if (|grant_o) ptr_d = grant_o[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two issue ports onto the shared ALU, waits the op latency, returns a tagged result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MULTI_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam logic [3:0] MULTI_CNT = 4'(MULTI_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        op_q, cnt_q;
  logic [DATA_W-1:0] a_q, b_q, rsp_data_q;
  logic              id_q, first_q;
  logic [1:0]        grant;
  logic              accept;
  logic [3:0]        op_in;
  logic [DATA_W-1:0] a_in, b_in;

  alu_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (rst_n && (state_q == IDLE)),
    .valid_i ({req1_valid, req0_valid}),
    .grant_o (grant)
  );

  assign accept = |grant;
  assign op_in  = grant[1] ? req1_op : req0_op;
  assign a_in   = grant[1] ? req1_a  : req0_a;
  assign b_in   = grant[1] ? req1_b  : req0_b;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)       state_d = EXEC;
      EXEC:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Gated by rst_n so nothing handshakes while reset is held.
  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
    busy       = rst_n && (state_q != IDLE);
    rsp_valid  = rst_n && (state_q == RESP);
    alu_start  = rst_n && (state_q == EXEC) && first_q && is_multi(op_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        a_q     <= a_in;
        b_q     <= b_in;
        id_q    <= grant[1];
        cnt_q   <= is_multi(op_in) ? MULTI_CNT : 4'd0;
        first_q <= 1'b1;
      end
      if (state_q == EXEC) begin
        first_q <= 1'b0;
        if (cnt_q == 4'd0) rsp_data_q <= alu_result;
        else               cnt_q      <= cnt_q - 4'd1;
      end
    end
  end

  assign alu_sel  = op_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign rsp_id   = id_q;
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v [2];
  logic [3:0]    op [2];
  logic [DW-1:0] a [2];
  logic [DW-1:0] b [2];
  logic          r [2];
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_a, alu_b, alu_result, rsp_data;
  logic          alu_start, rsp_valid, rsp_ready, rsp_id, busy;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .MULTI_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(r[0]), .req0_op(op[0]), .req0_a(a[0]), .req0_b(b[0]),
    .req1_valid(v[1]), .req1_ready(r[1]), .req1_op(op[1]), .req1_a(a[1]), .req1_b(b[1]),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  function automatic logic [DW-1:0] alu_model(input logic [3:0] s, input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (s)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x & y;
      4'h3: return x | y;
      4'h4: return x ^ y;
      4'h5: return ~(x | y);
      4'h6: return x << y[4:0];
      4'h7: return x >> y[4:0];
      4'h8: return x ^ 32'h5A5A_5A5A;
      4'h9: return 32'($signed(x) < $signed(y));
      4'hA: return 32'(x < y);
      4'hB: return y;
      4'hC: return x * y;
      4'hD: return {x[15:0], y[15:0]};
      4'hE: return x + y + 32'd1;
      default: return ~x;
    endcase
  endfunction

  assign alu_result = alu_model(alu_sel, alu_a, alu_b);

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected responses in issue order, arbitration favour, last issued op.
  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          expq[$];
  int            grant_log[$];
  int            cyc = 0;
  logic          favour = 1'b0;
  bit            rsp_seen = 1'b0;
  int            acc_cyc = -1000;
  int            acc_len = 1;
  logic [3:0]    acc_op = 4'h0;
  logic [DW-1:0] acc_a = '0;
  logic          acc [2];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (!rst_n) begin
      expq.delete();
      favour   = 1'b0;
      rsp_seen = 1'b0;
      acc_cyc  = -1000;
    end else begin
      if (busy) check_eq("rdy_while_busy", 32'(r[0] | r[1]), 32'd0);
      if (v[0] && v[1]) check_eq("one_ready", 32'(r[0] & r[1]), 32'd0);
      if (cyc > acc_cyc && cyc <= acc_cyc + acc_len) begin
        check_eq("alu_sel_hold", 32'(alu_sel), 32'(acc_op));
        check_eq("alu_a_hold", alu_a, acc_a);
      end
      check_eq("alu_start", 32'(alu_start), 32'(cyc == acc_cyc + 1 && acc_op >= 4'hC));
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          check_eq("rsp_spurious", 32'd1, 32'd0);
        end else begin
          check_eq("rsp_id", 32'(rsp_id), 32'(expq[0].id));
          check_eq("rsp_data", rsp_data, expq[0].data);
          if (!rsp_seen) check_eq("rsp_latency", 32'(cyc), 32'(expq[0].due));
          rsp_seen = 1'b1;
          if (rsp_ready) begin
            void'(expq.pop_front());
            rsp_seen = 1'b0;
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (v[p] && r[p]) begin
          int winner;
          int len;
          winner = (v[0] && v[1]) ? int'(favour) : (v[1] ? 1 : 0);
          check_eq("grant_choice", 32'(p), 32'(winner));
          len = (op[p] >= 4'hC) ? ML : 1;
          expq.push_back('{id: p[0], data: alu_model(op[p], a[p], b[p]), due: cyc + len + 1});
          grant_log.push_back(p);
          favour  = ~p[0];
          acc_cyc = cyc;
          acc_len = len;
          acc_op  = op[p];
          acc_a   = a[p];
          acc[p]  = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [3:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    v[p] = 1'b1; op[p] = o; a[p] = x; b[p] = y;
  endtask

  task automatic wait_acc(input int p);
    int n = 0;
    do begin
      step();
      n++;
    end while (!acc[p] && n < 100);
    check_eq("accept_timeout", 32'(acc[p]), 32'd1);
    v[p] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rsp_valid) && n < 100) begin
      step();
      n++;
    end
    check_eq("idle_timeout", 32'(n < 100), 32'd1);
  endtask

  initial begin
    int cnt [2];
    int n;
    logic [DW-1:0] exp_d;

    // Reset held with a pending request
    rst_n = 1'b0; rsp_ready = 1'b1;
    v[1] = 1'b0; op[1] = 4'h0; a[1] = '0; b[1] = '0;
    set_req(0, 4'h0, 32'd5, 32'd3);
    step(); step();
    check_eq("rst_ready0", 32'(r[0]), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_alu_sel", 32'(alu_sel), 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_b", alu_b, 32'd0);
    check_eq("rst_alu_start", 32'(alu_start), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("first_cycle_ready", 32'(r[0]), 32'd1);
    step();
    check_eq("first_accept", 32'(acc[0]), 32'd1);
    v[0] = 1'b0;
    wait_idle();

    // Single-cycle op from port 1
    set_req(1, 4'h2, 32'h0000_00FF, 32'h0F);
    wait_acc(1);
    step();
    check_eq("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("single_rsp_id", 32'(rsp_id), 32'd1);
    check_eq("single_rsp_data", rsp_data, 32'h0000_000F);
    wait_idle();

    // Multi-cycle op from port 0
    set_req(0, 4'hD, $urandom, $urandom);
    wait_acc(0);
    n = 0;
    for (int i = 0; i < ML; i++) begin
      check_eq("multi_sel", 32'(alu_sel), 32'hD);
      n += int'(alu_start);
      step();
    end
    check_eq("multi_start_count", 32'(n), 32'd1);
    check_eq("multi_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_idle();

    // Both ports continuously valid, six ops each, starting fresh from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    grant_log.delete();
    cnt[0] = 0; cnt[1] = 0;
    set_req(0, 4'($urandom_range(0, 11)), $urandom, $urandom);
    set_req(1, 4'($urandom_range(0, 11)), $urandom, $urandom);
    n = 0;
    while ((cnt[0] < 6 || cnt[1] < 6) && n < 400) begin
      step();
      n++;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          cnt[p]++;
          if (cnt[p] < 6) set_req(p, 4'($urandom_range(0, 11)), $urandom, $urandom);
          else v[p] = 1'b0;
        end
      end
    end
    check_eq("rr_count", 32'(grant_log.size()), 32'd12);
    for (int i = 0; i < grant_log.size(); i++)
      check_eq("rr_order", 32'(grant_log[i]), 32'(i % 2));
    wait_idle();

    // Response backpressure with another request waiting
    rsp_ready = 1'b0;
    set_req(1, 4'h3, $urandom, $urandom);
    exp_d = alu_model(op[1], a[1], b[1]);
    wait_acc(1);
    set_req(0, 4'h0, $urandom, $urandom);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rsp_data", rsp_data, exp_d);
      check_eq("bp_ready0", 32'(r[0]), 32'd0);
      check_eq("bp_busy", 32'(busy), 32'd1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check_eq("bp_next_grant", 32'(r[0]), 32'd1);
    step();
    v[0] = 1'b0;
    wait_idle();

    // Reset in the second EXEC cycle of a multi-cycle op
    set_req(0, 4'hE, $urandom, $urandom);
    wait_acc(0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_eq("midrst_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_eq("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end

    // Random traffic with random response backpressure
    for (int i = 0; i < 600; i++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) v[p] = 1'b0;
        if (!v[p] && $urandom_range(0, 2) == 0)
          set_req(p, 4'($urandom_range(0, 15)), $urandom, $urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    n = 0;
    while ((v[0] || v[1]) && n < 100) begin
      rsp_ready = 1'b1;
      step();
      n++;
      for (int p = 0; p < 2; p++) if (acc[p]) v[p] = 1'b0;
    end
    rsp_ready = 1'b1;
    wait_idle();
    step();
    check_eq("drain_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
